// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, reads the combinational ROM and
// presents each word to decode through a valid/ready IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        halted
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipc4_q, ipc4_d;
  logic        load;
  logic        zero_word;

  // Decode may take a new word when the register is empty or being drained.
  assign load      = (state_q == StRun) && (!valid_q || id_ready);
  assign zero_word = HALT_ON_ZERO && (imem_rdata == 32'h0);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    if (redirect_valid) begin
      // Flush: the word currently on imem_rdata is discarded.
      pc_d    = redirect_pc & ~32'h3;
      valid_d = 1'b0;
      state_d = StRun;
    end else if (load && zero_word) begin
      state_d = StHalt;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = imem_rdata;
      ipc_d   = pc_q;
      ipc4_d  = pc_q + 32'd4;
      valid_d = 1'b1;
      pc_d    = pc_q + 32'd4;
    end else if ((state_q == StHalt) && valid_q && id_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= Nop;
      ipc_q   <= RESET_PC;
      ipc4_q  <= RESET_PC + 32'd4;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc       = ipc_q;
  assign if_pc_plus4 = ipc4_q;
  assign halted      = (state_q == StHalt);

  // A stalled, unflushed instruction must be held steady for decode.
  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (if_valid && !id_ready && !redirect_valid) |=>
      $stable({if_valid, if_instr, if_pc, if_pc_plus4}));

endmodule
